// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding and constants for the memory access sequencer.
package mem_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t LOAD_MAR = 3'd1;
  localparam state_t LOAD_MDR = 3'd2;
  localparam state_t RD_ACC   = 3'd3;
  localparam state_t WR_ACC   = 3'd4;
  localparam state_t RD_CAP   = 3'd5;
  localparam state_t DONE     = 3'd6;
  localparam state_t ERR      = 3'd7;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int WAIT_CYCLES_DEF = 1;
  localparam int TIMEOUT_DEF     = 15;

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Loadable 4-bit down-counter that holds at zero; paces RAM wait states.
module wait_counter (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      cnt <= 4'd0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != 4'd0))
      cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one MAR/MDR/RAM transaction per start pulse.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for start, rw latched on accept
// LOAD_MAR | address on bus, MARin
// LOAD_MDR | write data on bus, MDRin from bus
// RD_ACC   | RAM read strobe, waiting for wait count and mem_ready
// WR_ACC   | RAM write strobe, waiting for wait count and mem_ready
// RD_CAP   | capture Mdatain into MDR
// DONE     | one-cycle completion pulse
// ERR      | one-cycle completion pulse with err (timeout build only)
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic rw,
  input  logic mem_ready,
  output logic MARin,
  output logic MDRin,
  output logic MDRRead,
  output logic RAMread,
  output logic RAMwrite,
  output logic busy,
  output logic done,
  output logic err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("mem_access_ctrl: WAIT_CYCLES or TIMEOUT out of range");
  end

  state_t state, state_nxt;
  logic   rw_q;
  logic   in_acc;
  logic   wc_zero;
  logic   acc_exit;
  logic   timed_out;

  assign in_acc   = (state == RD_ACC) || (state == WR_ACC);
  assign acc_exit = wc_zero && mem_ready;

  // Reloads every cycle outside the access states, so entry always sees WAIT_CYCLES.
  wait_counter u_wait (
    .clk      (clk),
    .clr      (clr),
    .load     (!in_acc),
    .dec      (in_acc),
    .load_val (4'(WAIT_CYCLES)),
    .zero     (wc_zero)
  );

`ifdef MEM_TIMEOUT_EN
  logic [7:0] to_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      to_cnt <= 8'd0;
    else if (!in_acc)
      to_cnt <= 8'd0;
    else
      to_cnt <= to_cnt + 8'd1;
  end

  // Fires on the TIMEOUT-th access cycle so ERR follows immediately after it.
  assign timed_out = ({1'b0, to_cnt} + 9'd1) >= 9'(TIMEOUT);
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      rw_q <= RW_READ;
    else if ((state == IDLE) && start)
      rw_q <= rw;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = LOAD_MAR;
      LOAD_MAR: state_nxt = (rw_q == RW_WRITE) ? LOAD_MDR : RD_ACC;
      LOAD_MDR: state_nxt = WR_ACC;
      RD_ACC: begin
        if (acc_exit)       state_nxt = RD_CAP;
        else if (timed_out) state_nxt = ERR;
      end
      WR_ACC: begin
        if (acc_exit)       state_nxt = DONE;
        else if (timed_out) state_nxt = ERR;
      end
      RD_CAP:   state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      ERR:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRRead  = 1'b0;
    RAMread  = 1'b0;
    RAMwrite = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    busy     = (state != IDLE);
    case (state)
      LOAD_MAR: MARin = 1'b1;
      LOAD_MDR: MDRin = 1'b1;
      RD_ACC: begin
        RAMread = 1'b1;
        MDRRead = 1'b1;
      end
      WR_ACC:   RAMwrite = 1'b1;
      RD_CAP: begin
        RAMread = 1'b1;
        MDRRead = 1'b1;
        MDRin   = 1'b1;
      end
      DONE:     done = 1'b1;
      ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
